mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter ADDR_W, 15, MMIO address width.
REQ-002 Parameter DATA_W, 16, MMIO data width.
REQ-003 Parameter WINDOW, 32, number of decoded MMIO addresses; addresses >= WINDOW are out of range.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  2  per-requester access request; bit 0 = CPU, bit 1 = debug bridge.
REQ-007 req_we  in  2  per-requester write flag.
REQ-008 req_addr  in  2*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  in  2*DATA_W  packed write data, same packing.
REQ-010 req_ready  out  2  one-hot acceptance strobe.
REQ-011 rsp_valid  out  2  one-hot, one-cycle response strobe.
REQ-012 rsp_rdata  out  DATA_W  read data, valid while any rsp_valid bit is high.
REQ-013 rsp_err  out  1  out-of-range flag, valid with rsp_valid.
REQ-014 mmio_addr  out  ADDR_W  address to the MMIO decoder.
REQ-015 mmio_we  out  1  write strobe to the MMIO decoder.
REQ-016 mmio_wdata  out  DATA_W  write data to the MMIO decoder.
REQ-017 mmio_rdata  in  DATA_W  combinational read data from the MMIO decoder.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; transitions IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-020 In IDLE with any req_valid bit set, the grant index g is chosen by round-robin and req_ready[g] is driven high combinationally in that cycle; this is the accept cycle T.
REQ-021 Round-robin: if both requesters are valid, grant the one not granted last; if one is valid, grant it; last_grant updates only on accept.
REQ-022 On accept, latch req_addr, req_we and req_wdata of requester g, plus g.
REQ-023 req_ready is low in ACCESS and RESP; a requester holds valid and payload stable until it sees ready.
REQ-024 ACCESS (cycle T+1): mmio_addr and mmio_wdata carry the latched values; mmio_we = latched we AND (addr < WINDOW); mmio_we is high for exactly this one cycle.
REQ-025 At the end of ACCESS, register rsp_rdata = mmio_rdata for an in-range read, otherwise 0; register rsp_err = (addr >= WINDOW).
REQ-026 RESP (cycle T+2): rsp_valid[g] is high for exactly one cycle; response latency is 2 cycles after accept; peak throughput is 1 access per 3 cycles.
REQ-027 An in-range write returns rsp_rdata = 0 and rsp_err = 0.
REQ-028 An out-of-range access never asserts mmio_we and returns rsp_rdata = 0 and rsp_err = 1.
REQ-029 Outside ACCESS, mmio_we = 0; mmio_addr and mmio_wdata hold their last latched values.
REQ-030 A req_valid that drops before acceptance is ignored; valid changes outside IDLE have no effect on the access in flight.

Reset
REQ-031 While rst_n = 0: state = IDLE, last_grant = 1 (CPU wins the first tie), all latches = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mmio_addr = 0, mmio_we = 0, mmio_wdata = 0, busy = 0.
REQ-032 A reset during ACCESS or RESP aborts the access; no rsp_valid is produced for it, and mmio_we falls immediately (asynchronously).
REQ-033 After reset deassertion, the first accept can occur in the first clock cycle.

Structure
REQ-034 Shared package mmio_pkg holds the state encoding (IDLE=0, ACCESS=1, RESP=2), the ADDR_W/DATA_W defaults and the WINDOW constant.
REQ-035 The round-robin selection is a sub-module rr_arbiter2 with inputs (req[1:0], last) and one-hot output grant.
REQ-036 All other logic stays in one module, with one registered FSM and one output register bank.

Verification
REQ-037 CPU read only: addr=5, mmio_rdata=0x0001 -> req_ready[0] at T, mmio_addr=5 with mmio_we=0 at T+1, rsp_valid[0] with rsp_rdata=0x0001 and rsp_err=0 at T+2.
REQ-038 Both requesters valid from reset, continuously -> grants in order 0,1,0,1, accepts 3 cycles apart, no starvation.
REQ-039 Debug write: addr=20, wdata=0x0001 -> mmio_we high for exactly 1 cycle with mmio_addr=20; rsp_valid[1] with rsp_rdata=0 and rsp_err=0.
REQ-040 Out of range: write to addr=32 -> mmio_we stays 0; rsp_err=1 and rsp_rdata=0.
REQ-041 rst_n pulsed low during ACCESS -> mmio_we drops immediately; no rsp_valid; next request from requester 0 is granted first.
REQ-042 req_valid[1] asserted in ACCESS of a requester-0 access -> no req_ready[1] until the following IDLE, then granted.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO arbiter.
// State encoding plus address/data widths and the decoded window size.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 15;
  localparam int MMIO_DATA_W = 16;
  localparam int MMIO_WINDOW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mmio_arbiter_rr.sv
// Two-way round-robin selector.
// Grants the requester not granted last when both are asking.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Arbitrates CPU and debug-bridge accesses onto one MMIO decoder port.
// One access in flight: accept, drive the decoder, then respond.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W,
  parameter int WINDOW = MMIO_WINDOW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mmio_addr,
  output logic                mmio_we,
  output logic [DATA_W-1:0]   mmio_wdata,
  input  logic [DATA_W-1:0]   mmio_rdata,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] WIN_A = ADDR_W'(WINDOW);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [1:0]          grant;
  logic                in_range;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign in_range = addr_q < WIN_A;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = ACCESS;
          gnt_d   = grant[1];
          last_d  = grant[1];
          addr_d  = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W]
                             : req_addr[ADDR_W-1:0];
          wdata_d = grant[1] ? req_wdata[2*DATA_W-1:DATA_W]
                             : req_wdata[DATA_W-1:0];
          we_d    = grant[1] ? req_we[1] : req_we[0];
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (!we_q && in_range) ? mmio_rdata : '0;
        err_d   = !in_range;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Decoded from state so an async reset drops the strobes at once.
  assign req_ready  = (state_q == IDLE) ? grant : 2'b00;
  assign mmio_we    = (state_q == ACCESS) && we_q && in_range;
  assign mmio_addr  = addr_q;
  assign mmio_wdata = wdata_q;
  assign rsp_valid  = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01)
                                        : 2'b00;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign busy       = state_q != IDLE;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter with hand-computed expectations.
module tb_mmio_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mmio_addr;
  logic          mmio_we;
  logic [DW-1:0] mmio_wdata;
  logic [DW-1:0] mmio_rdata;
  logic          busy;

  int n_chk;
  int n_err;

  mmio_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mmio_addr  (mmio_addr),
    .mmio_we    (mmio_we),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mmio_rdata = '0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mmio_we, 0);
    chk("rst_addr", mmio_addr, 0);
    chk("rst_wdata", mmio_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);

    // CPU read of addr 5, accepted in the first cycle after reset
    cyc();
    rst_n = 1'b1;
    req_valid = 2'b01;
    set_req(0, 1'b0, 15'd5, 16'h0);
    mmio_rdata = 16'h0001;
    #1;
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_busy0", busy, 0);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("rd_busy1", busy, 1);
    chk("rd_addr", mmio_addr, 5);
    chk("rd_we", mmio_we, 0);
    chk("rd_noready", req_ready, 0);
    cyc();
    #1;
    chk("rd_rsp", rsp_valid, 2'b01);
    chk("rd_data", rsp_rdata, 16'h0001);
    chk("rd_err", rsp_err, 0);
    cyc();
    #1;
    chk("rd_rsp_end", rsp_valid, 0);
    chk("rd_idle", busy, 0);

    // Debug write to addr 20
    req_valid = 2'b10;
    set_req(1, 1'b1, 15'd20, 16'h0001);
    mmio_rdata = 16'hBEEF;
    #1;
    chk("dw_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("dw_we", mmio_we, 1);
    chk("dw_addr", mmio_addr, 20);
    chk("dw_wdata", mmio_wdata, 1);
    cyc();
    #1;
    chk("dw_we_off", mmio_we, 0);
    chk("dw_rsp", rsp_valid, 2'b10);
    chk("dw_data", rsp_rdata, 0);
    chk("dw_err", rsp_err, 0);
    cyc();

    // CPU write to addr 32 is out of range
    req_valid = 2'b01;
    set_req(0, 1'b1, 15'd32, 16'h0055);
    #1;
    chk("oor_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("oor_we", mmio_we, 0);
    chk("oor_addr", mmio_addr, 32);
    cyc();
    #1;
    chk("oor_rsp", rsp_valid, 2'b01);
    chk("oor_err", rsp_err, 1);
    chk("oor_data", rsp_rdata, 0);
    cyc();

    // Debug read of addr 31, last in-range address
    req_valid = 2'b10;
    set_req(1, 1'b0, 15'd31, 16'h0);
    #1;
    chk("b31_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("b31_we", mmio_we, 0);
    cyc();
    #1;
    chk("b31_rsp", rsp_valid, 2'b10);
    chk("b31_data", rsp_rdata, 16'hBEEF);
    chk("b31_err", rsp_err, 0);
    cyc();

    // Debug request raised while a CPU access is in flight
    req_valid = 2'b01;
    set_req(0, 1'b0, 15'd3, 16'h0);
    mmio_rdata = 16'h1234;
    #1;
    chk("lt_ready0", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10;
    set_req(1, 1'b0, 15'd7, 16'h0);
    #1;
    chk("lt_acc_rdy", req_ready, 0);
    cyc();
    #1;
    chk("lt_rsp_rdy", req_ready, 0);
    chk("lt_rsp0", rsp_valid, 2'b01);
    chk("lt_data0", rsp_rdata, 16'h1234);
    cyc();
    #1;
    chk("lt_ready1", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("lt_addr1", mmio_addr, 7);
    cyc();
    #1;
    chk("lt_rsp1", rsp_valid, 2'b10);
    cyc();

    // Reset during ACCESS of a CPU write
    req_valid = 2'b01;
    set_req(0, 1'b1, 15'd10, 16'h00A5);
    #1;
    chk("ra_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("ra_we_on", mmio_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ra_we_off", mmio_we, 0);
    chk("ra_busy", busy, 0);
    chk("ra_addr", mmio_addr, 0);
    cyc();
    #1;
    chk("ra_norsp0", rsp_valid, 0);
    cyc();
    #1;
    chk("ra_norsp1", rsp_valid, 0);

    // Both valid continuously after reset: 0,1,0,1 every 3 cycles
    rst_n = 1'b1;
    req_valid = 2'b11;
    set_req(0, 1'b0, 15'd4, 16'h0);
    set_req(1, 1'b0, 15'd6, 16'h0);
    #1;
    chk("rr_c0", req_ready, 2'b01);
    for (int i = 1; i < 12; i++) begin
      cyc();
      #1;
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      if (i % 3 == 0)
        exp_rdy = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
      if (i % 3 == 2)
        exp_rsp = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("rr_rdy%0d", i), req_ready, exp_rdy);
      chk($sformatf("rr_rsp%0d", i), rsp_valid, exp_rsp);
    end
    req_valid = 2'b00;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
